// File: rtl/can_rx_pkg.sv
// Shared constants and the DLC-to-payload mapping for the CAN receive buffer.
package can_rx_pkg;

    localparam logic [7:0]  WIN_BASE = 8'h10;
    localparam logic [7:0]  CMD_ADDR = 8'h01;
    localparam int unsigned RRB_BIT  = 2;

    localparam int unsigned FF_BIT   = 7;
    localparam int unsigned RTR_BIT  = 6;
    localparam int unsigned FDF_BIT  = 5;

    // Payload byte count for a DLC; FD frames use the non-linear upper codes.
    function automatic logic [6:0] dlc2len(input logic [3:0] dlc, input logic fdf);
        logic [6:0] len;
        len = {3'b000, dlc};
        if (!fdf) begin
            if (dlc > 4'd8) begin
                len = 7'd8;
            end
        end else begin
            case (dlc)
                4'd9:    len = 7'd12;
                4'd10:   len = 7'd16;
                4'd11:   len = 7'd20;
                4'd12:   len = 7'd24;
                4'd13:   len = 7'd32;
                4'd14:   len = 7'd48;
                4'd15:   len = 7'd64;
                default: len = {3'b000, dlc};
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/can_rx_frame_len.sv
// Total stored length of a received frame (info byte + ID bytes + payload).
module can_rx_frame_len
    import can_rx_pkg::*;
(
    input  logic [7:0] info_i,
    output logic [6:0] len_o
);

    logic [6:0] payload;
    logic       unused_info;

    assign unused_info = info_i[4];

    always_comb begin
        payload = dlc2len(info_i[3:0], info_i[FDF_BIT]);
        // Classic remote frames carry no data regardless of DLC.
        if (info_i[RTR_BIT] && !info_i[FDF_BIT]) begin
            payload = 7'd0;
        end
        len_o = 7'd1 + (info_i[FF_BIT] ? 7'd4 : 7'd2) + payload;
    end

endmodule

// File: rtl/can_rx_buf_window.sv
// Circular RX FIFO with a CPU read window, release command and overrun detection.
// Optional CAN_RX_AUTO_RELEASE_EN: reading the last byte of the current frame releases it.
module can_rx_buf_window
    import can_rx_pkg::*;
#(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned WIN_SIZE = 80
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_re_i,
    input  logic              reg_we_i,
    input  logic [7:0]        reg_addr_i,
    input  logic [7:0]        reg_data_i,
    output logic              win_hit_o,
    output logic [7:0]        win_data_o,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_commit_i,
    input  logic              wr_abort_i,
    output logic [6:0]        rx_msg_cnt_o,
    output logic              rbs_o,
    output logic [ADDR_W-1:0] rbsa_o,
    output logic              overrun_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [7:0]       ram_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_base_q, wr_base_d;
    logic [PTR_W-1:0] wr_tmp_q, wr_tmp_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       win_data_q, win_data_d;

    logic [PTR_W-1:0] used;
    logic             full;
    logic             byte_ok;
    logic             drop_eff;
    logic             commit_ok;
    logic [7:0]       rd_info;
    logic [6:0]       rd_len;
    logic [7:0]       win_off;
    logic [ADDR_W-1:0] win_idx;
    logic             cmd_rel;
    logic             auto_rel;
    logic             rel;
    logic [4:0]       unused_data;

    assign unused_data = {reg_data_i[7:3], reg_data_i[1:0]};

    assign used = wr_tmp_q - rd_ptr_q;
    assign full = (used == PTR_W'(DEPTH));

    assign rd_info = ram_q[rd_ptr_q[ADDR_W-1:0]];

    can_rx_frame_len u_rel_len (
        .info_i (rd_info),
        .len_o  (rd_len)
    );

    // Window geometry
    assign win_hit_o = (reg_addr_i >= WIN_BASE) &&
                       (32'(reg_addr_i) < 32'(WIN_BASE) + WIN_SIZE);
    assign win_off   = reg_addr_i - WIN_BASE;
    // Truncation to ADDR_W bits is the wrap modulo DEPTH.
    assign win_idx   = ADDR_W'(32'(rd_ptr_q[ADDR_W-1:0]) + 32'(win_off));

    assign cmd_rel = reg_we_i && (reg_addr_i == CMD_ADDR) && reg_data_i[RRB_BIT];

`ifdef CAN_RX_AUTO_RELEASE_EN
    assign auto_rel = reg_re_i && win_hit_o &&
                      ({1'b0, win_off} == ({2'b00, rd_len} - 9'd1));
`else
    logic unused_re;
    assign unused_re = reg_re_i;
    assign auto_rel  = 1'b0;
`endif

    // Auto and command releases in the same cycle collapse into one.
    assign rel = (cmd_rel || auto_rel) && (cnt_q != 7'd0);

    always_comb begin
        byte_ok   = wr_en_i && !full && !drop_q;
        drop_eff  = drop_q || (wr_en_i && full);
        commit_ok = 1'b0;

        wr_tmp_d  = byte_ok ? wr_tmp_q + PTR_W'(1) : wr_tmp_q;
        wr_base_d = wr_base_q;
        drop_d    = drop_eff;
        overrun_d = 1'b0;

        if (wr_abort_i) begin
            wr_tmp_d = wr_base_q;
            drop_d   = 1'b0;
        end else if (wr_commit_i) begin
            if (drop_eff) begin
                wr_tmp_d  = wr_base_q;
                overrun_d = 1'b1;
                drop_d    = 1'b0;
            end else begin
                wr_base_d = wr_tmp_d;
                commit_ok = 1'b1;
            end
        end

        rd_ptr_d = rel ? rd_ptr_q + PTR_W'(rd_len) : rd_ptr_q;
        cnt_d    = cnt_q + {6'd0, commit_ok} - {6'd0, rel};

        win_data_d = win_hit_o ? ram_q[win_idx] : 8'h00;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_base_q  <= '0;
            wr_tmp_q   <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            overrun_q  <= 1'b0;
            win_data_q <= 8'h00;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_base_q  <= wr_base_d;
            wr_tmp_q   <= wr_tmp_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            overrun_q  <= overrun_d;
            win_data_q <= win_data_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (byte_ok) begin
            ram_q[wr_tmp_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    assign win_data_o   = win_data_q;
    assign rx_msg_cnt_o = cnt_q;
    assign rbs_o        = (cnt_q != 7'd0);
    assign rbsa_o       = rd_ptr_q[ADDR_W-1:0];
    assign overrun_o    = overrun_q;

endmodule

// File: doc/can_rx_buf_window.md
Name: can_rx_buf_window

Overview:
Receive-buffer stage directly downstream of the 8051 register-access interface in the SJA1000-FD receiver. It consumes the single-cycle reg_re/reg_we strobes, latched address and write data, and serves a CPU read window onto a circular RX FIFO RAM filled by the bit-stream processor. It handles the Release Receive Buffer command and produces receive message count, buffer start address and overrun indication for the register block.

Parameters:
DEPTH, 128, RX FIFO size in bytes; power of 2, range 64..256
ADDR_W, $clog2(DEPTH), FIFO byte pointer width
WIN_SIZE, 80, number of window bytes starting at address 8'h10

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
reg_re_i  in  1  read strobe, one cycle, from register-access interface
reg_we_i  in  1  write strobe, one cycle
reg_addr_i  in  8  latched register address
reg_data_i  in  8  CPU write data
win_hit_o  out  1  reg_addr_i is inside the window (combinational)
win_data_o  out  8  window read data, registered
wr_en_i  in  1  bit-stream processor writes one frame byte
wr_data_i  in  8  frame byte; the first byte of each frame is the info byte
wr_commit_i  in  1  frame complete, publish it
wr_abort_i  in  1  frame error, discard uncommitted bytes
rx_msg_cnt_o  out  7  committed unreleased frames (RMC)
rbs_o  out  1  receive buffer status, rx_msg_cnt_o != 0
rbsa_o  out  ADDR_W  current read pointer (RBSA)
overrun_o  out  1  one-cycle pulse when a frame is dropped for lack of space

Behaviour:
- Reset: rst_i, asynchronous, active-high; clock clk_i. All pointers, rx_msg_cnt_o, win_data_o, overrun_o and the drop flag reset to 0.
- Storage: reg array of DEPTH x 8 with asynchronous read. Pointers rd_ptr, wr_base (committed) and wr_tmp (in-progress) are ADDR_W+1 bits wide. used = wr_tmp - rd_ptr. FIFO is full when used == DEPTH.
- Info byte layout: bit7 FF (extended ID), bit6 RTR, bit5 FDF, bits3:0 DLC.
- Frame length = 1 + (FF ? 4 : 2) + payload.
  - Payload = 0 if RTR and not FDF.
  - Classic frames (FDF=0): payload = min(DLC, 8).
  - FD frames: DLC 0-8 maps to 0-8 bytes; DLC 9..15 maps to 12, 16, 20, 24, 32, 48, 64 bytes.
- Write path:
  - wr_en_i and not full and drop flag clear: RAM[wr_tmp] <= wr_data_i; wr_tmp++.
  - wr_en_i while full: byte discarded and drop flag set; later bytes of this frame are ignored.
  - wr_commit_i with drop clear: wr_base <= wr_tmp (including a byte written in the same cycle); rx_msg_cnt++.
  - wr_commit_i with drop set: wr_tmp <= wr_base; overrun_o pulses for one cycle; drop flag cleared.
  - wr_abort_i: wr_tmp <= wr_base; drop flag cleared; abort takes priority over commit.
- Release: reg_we_i with reg_addr_i==8'h01 and reg_data_i[2]=1 while rx_msg_cnt_o>0: rd_ptr += frame length of RAM[rd_ptr]; rx_msg_cnt--. Release while the count is 0 is ignored.
- Commit and release in the same cycle: both are applied and rx_msg_cnt_o is unchanged.
- Window:
  - win_hit_o = 8'h10 <= reg_addr_i < 8'h10+WIN_SIZE.
  - Every clock: win_data_o <= win_hit_o ? RAM[(rd_ptr + reg_addr_i - 8'h10) mod DEPTH] : 8'h00. Latency is 1 clk from an address change.
  - Bytes beyond the current frame return raw RAM contents (wrap mod DEPTH).
  - Window data follows rd_ptr on the cycle after a release.
- Writes to the window are ignored; the RAM is read-only to the CPU.
- reg_re_i is used only by the optional feature.
- rbsa_o = rd_ptr[ADDR_W-1:0].

Optional Feature:
CAN_RX_AUTO_RELEASE_EN:
- With the macro: a reg_re_i to window offset (current frame length - 1) while rx_msg_cnt_o>0 performs a release exactly as the command-register release does. If an auto and a command release occur in the same cycle, one release is applied.
- Without the macro: reg_re_i is unused and release happens only via the command register.

Decomposition:
- Package can_rx_pkg holds:
  - WIN_BASE=8'h10, CMD_ADDR=8'h01, RRB_BIT=2
  - info-byte bit positions FF_BIT, RTR_BIT, FDF_BIT
  - function dlc2len(dlc, fdf) returning 7 bits
- Sub-module can_rx_frame_len: combinational info byte -> frame length (7 bits).
  - Instantiated for the release path.
  - Reused for the auto-release compare when the macro is enabled.

Test Plan:
- Write a standard frame (info 0x08, 2 ID bytes, 8 data bytes 0xA0..0xA7), then commit -> rx_msg_cnt_o=1, rbs_o=1; reading addr 0x10 gives 0x08 and addr 0x13 gives 0xA0, each one clk after the address is applied.
- Release via reg_we_i addr 0x01 data 0x04 -> rbsa_o=11, rx_msg_cnt_o=0. A second release leaves everything unchanged.
- FD extended frame, info 0xAF (FF, FDF, DLC 15) -> length 69; after release rbsa_o advances by 69. Start with rd_ptr=100 to exercise wrap: window offset 30 reads RAM[2].
- Fill to used=DEPTH-3, then start an 11-byte frame and commit -> overrun_o pulses once, rx_msg_cnt_o unchanged, wr_tmp restored; the next frame is accepted after a release.
- wr_abort_i midway through 5 bytes -> nothing committed; the next frame's info byte lands at the old wr_base.
- Commit and release in the same cycle with count=1 -> count stays 1, rbsa_o advances. Assert rst_i mid-frame -> all outputs 0 asynchronously.
